// File: rtl/pht_pkg.sv
// Shared types, constants and helpers for the gshare pattern history table.
package pht_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } pht_state_e;

  localparam logic [1:0] PHT_ACT_NONE    = 2'b00;
  localparam logic [1:0] PHT_ACT_COMMIT  = 2'b01;
  localparam logic [1:0] PHT_ACT_MISPRED = 2'b10;

  localparam int unsigned PHT_CNT_INIT = 1;

  function automatic logic [31:0] sat_cnt(
    input logic [31:0] cnt,
    input logic        take,
    input int unsigned bits
  );
    logic [31:0] lim;
    lim = (32'd1 << bits) - 32'd1;
    if (take)
      return (cnt >= lim) ? lim : cnt + 32'd1;
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

  // Caller truncates the result to its index width.
  function automatic logic [31:0] pht_index(
    input logic [31:0] pc,
    input logic [31:0] bhr
  );
    return (pc >> 2) ^ bhr;
  endfunction

endpackage

// File: rtl/pht_counter_ram.sv
// Counter table: one write port, FETCH_WIDTH asynchronous read ports.
module pht_counter_ram #(
  parameter int INDEX_BITS  = 8,
  parameter int CNT_BITS    = 2,
  parameter int FETCH_WIDTH = 4
) (
  input  logic                                  clk,
  input  logic                                  i_we,
  input  logic [INDEX_BITS-1:0]                 i_waddr,
  input  logic [CNT_BITS-1:0]                   i_wdata,
  input  logic [FETCH_WIDTH-1:0][INDEX_BITS-1:0] i_raddr,
  output logic [FETCH_WIDTH-1:0][CNT_BITS-1:0]   o_rdata
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [CNT_BITS-1:0] r_mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      o_rdata[i] = r_mem[i_raddr[i]];
  end

endmodule

// File: rtl/pht_gshare_multiport.sv
// Multi-lane gshare direction predictor: init FSM, global history,
// lookup hashing and registered per-lane predictions.
module pht_gshare_multiport
  import pht_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int INDEX_BITS  = 8,
  parameter int BHR_LEN     = 8,
  parameter int CNT_BITS    = 2,
  localparam int CKPT_W     = BHR_LEN + CNT_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic                          lookup_valid,
  input  logic [31:0]                   lookup_vaddr,
  output logic                          pred_valid,
  output logic [FETCH_WIDTH-1:0]        pred_take,
  output logic [FETCH_WIDTH*CKPT_W-1:0] pred_ckpt,
  input  logic                          spec_valid,
  input  logic                          spec_take,
  input  logic [1:0]                    upd_action,
  input  logic [CKPT_W-1:0]             upd_ckpt,
  input  logic [31:0]                   upd_vaddr,
  input  logic                          upd_take
);

  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  pht_state_e r_state;
  pht_state_e w_state_nxt;
  logic [INDEX_BITS-1:0] r_init_ptr;
  logic [INDEX_BITS-1:0] w_ptr_nxt;
  logic [BHR_LEN-1:0] r_bhr;
  logic [BHR_LEN-1:0] w_bhr_nxt;

  logic r_pred_valid;
  logic [FETCH_WIDTH-1:0] r_pred_take;
  logic [FETCH_WIDTH*CKPT_W-1:0] r_pred_ckpt;
  logic [FETCH_WIDTH-1:0] w_take_nxt;
  logic [FETCH_WIDTH*CKPT_W-1:0] w_ckpt_nxt;

  logic w_run;
  logic w_lookup;
  logic w_upd_en;
  logic w_mispred;
  logic [CNT_BITS-1:0] w_ckpt_cnt;
  logic [BHR_LEN-1:0] w_ckpt_bhr;
  logic [INDEX_BITS-1:0] w_upd_idx;

  logic [31:0] w_lane_pc [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0][INDEX_BITS-1:0] w_ridx;
  logic [FETCH_WIDTH-1:0][CNT_BITS-1:0] w_rdata;

  logic w_we;
  logic [INDEX_BITS-1:0] w_waddr;
  logic [CNT_BITS-1:0] w_wdata;

  assign w_run      = (r_state == ST_RUN);
  assign ready      = w_run;
  assign w_lookup   = lookup_valid && w_run;
  assign w_mispred  = (upd_action == PHT_ACT_MISPRED);
  assign w_upd_en   = (upd_action == PHT_ACT_COMMIT) || w_mispred;
  assign w_ckpt_cnt = upd_ckpt[CNT_BITS-1:0];
  assign w_ckpt_bhr = upd_ckpt[CKPT_W-1:CNT_BITS];
  assign w_upd_idx  = INDEX_BITS'(pht_index(upd_vaddr,
                        32'(w_ckpt_bhr[INDEX_BITS-1:0])));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_init_ptr;
    unique case (r_state)
      ST_INIT: begin
        w_ptr_nxt = r_init_ptr + 1'b1;
        if (r_init_ptr == LAST_IDX)
          w_state_nxt = ST_RUN;
      end
      ST_RUN: w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_ptr_nxt;
    end
  end

  // Init sweep owns the single write port; updates only land in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!w_run) begin
      w_we    = rst;
      w_waddr = r_init_ptr;
      w_wdata = CNT_BITS'(PHT_CNT_INIT);
    end else if (w_upd_en) begin
      w_we    = rst;
      w_waddr = w_upd_idx;
      w_wdata = CNT_BITS'(sat_cnt(32'(w_ckpt_cnt), upd_take, CNT_BITS));
    end
  end

  always_comb begin
    w_bhr_nxt = r_bhr;
    if (w_mispred)
      w_bhr_nxt = {w_ckpt_bhr[BHR_LEN-2:0], upd_take};
    else if (spec_valid)
      w_bhr_nxt = {r_bhr[BHR_LEN-2:0], spec_take};
  end

  always_comb begin
    w_take_nxt = '0;
    w_ckpt_nxt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_lane_pc[i] = lookup_vaddr + (32'(i) << 2);
      w_ridx[i] = INDEX_BITS'(pht_index(w_lane_pc[i],
                    32'(r_bhr[INDEX_BITS-1:0])));
      w_take_nxt[i] = w_rdata[i][CNT_BITS-1];
      w_ckpt_nxt[i*CKPT_W +: CKPT_W] = {r_bhr, w_rdata[i]};
    end
  end

  pht_counter_ram #(
    .INDEX_BITS (INDEX_BITS),
    .CNT_BITS   (CNT_BITS),
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_ridx),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bhr        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_take  <= '0;
      r_pred_ckpt  <= '0;
    end else begin
      r_bhr        <= w_bhr_nxt;
      r_pred_valid <= w_lookup;
      if (w_lookup) begin
        r_pred_take <= w_take_nxt;
        r_pred_ckpt <= w_ckpt_nxt;
      end
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred_take  = r_pred_take;
  assign pred_ckpt  = r_pred_ckpt;

endmodule
